// File: rtl/watch_pkg.sv
// Shared types, field encodings, ranges and calendar helpers for the watch time setter and counter.
package watch_pkg;

    localparam int unsigned FIELD_W = 8;
    localparam int unsigned TIME_W  = 48;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        E_YEAR  = 3'd1,
        E_MONTH = 3'd2,
        E_DAY   = 3'd3,
        E_HOUR  = 3'd4,
        E_MIN   = 3'd5,
        E_SEC   = 3'd6,
        COMMIT  = 3'd7
    } state_e;

    localparam logic [IDX_W-1:0] FIELD_YEAR  = 3'd0;
    localparam logic [IDX_W-1:0] FIELD_MONTH = 3'd1;
    localparam logic [IDX_W-1:0] FIELD_DAY   = 3'd2;
    localparam logic [IDX_W-1:0] FIELD_HOUR  = 3'd3;
    localparam logic [IDX_W-1:0] FIELD_MIN   = 3'd4;
    localparam logic [IDX_W-1:0] FIELD_SEC   = 3'd5;
    localparam logic [IDX_W-1:0] FIELD_NONE  = 3'd7;

    localparam logic [FIELD_W-1:0] YEAR_MIN   = 8'd0;
    localparam logic [FIELD_W-1:0] YEAR_MAX   = 8'd255;
    localparam logic [FIELD_W-1:0] MONTH_MIN  = 8'd1;
    localparam logic [FIELD_W-1:0] MONTH_MAX  = 8'd12;
    localparam logic [FIELD_W-1:0] DAY_MIN    = 8'd1;
    localparam logic [FIELD_W-1:0] HOUR_MIN   = 8'd0;
    localparam logic [FIELD_W-1:0] HOUR_MAX   = 8'd23;
    localparam logic [FIELD_W-1:0] MINUTE_MIN = 8'd0;
    localparam logic [FIELD_W-1:0] MINUTE_MAX = 8'd59;
    localparam logic [FIELD_W-1:0] SECOND_MIN = 8'd0;
    localparam logic [FIELD_W-1:0] SECOND_MAX = 8'd59;

    typedef struct packed {
        logic [FIELD_W-1:0] year;
        logic [FIELD_W-1:0] month;
        logic [FIELD_W-1:0] day;
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] minute;
        logic [FIELD_W-1:0] second;
    } watch_time_t;

    // No leap years: February is always 28 days, matching the counter.
    function automatic logic [FIELD_W-1:0] max_days(input logic [FIELD_W-1:0] month);
        case (month)
            8'd2:                    return 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

    function automatic logic is_edit(input state_e st);
        return st inside {E_YEAR, E_MONTH, E_DAY, E_HOUR, E_MIN, E_SEC};
    endfunction

    function automatic logic [IDX_W-1:0] state_field(input state_e st);
        case (st)
            E_YEAR:  return FIELD_YEAR;
            E_MONTH: return FIELD_MONTH;
            E_DAY:   return FIELD_DAY;
            E_HOUR:  return FIELD_HOUR;
            E_MIN:   return FIELD_MIN;
            E_SEC:   return FIELD_SEC;
            default: return FIELD_NONE;
        endcase
    endfunction

    function automatic state_e next_field_state(input state_e st);
        case (st)
            E_YEAR:  return E_MONTH;
            E_MONTH: return E_DAY;
            E_DAY:   return E_HOUR;
            E_HOUR:  return E_MIN;
            E_MIN:   return E_SEC;
            E_SEC:   return COMMIT;
            default: return IDLE;
        endcase
    endfunction

    // Force an out-of-range month or day from the live counter to 1 before editing.
    function automatic watch_time_t sanitize(input watch_time_t t);
        watch_time_t r;
        r = t;
        if (r.month < MONTH_MIN || r.month > MONTH_MAX) r.month = MONTH_MIN;
        if (r.day < DAY_MIN || r.day > max_days(r.month)) r.day = DAY_MIN;
        return r;
    endfunction

endpackage

// File: rtl/watch_time_setter_if.sv
// Button, live-time and load-side signals between the front-end, the setter and the counter.
interface watch_time_setter_if;
    import watch_pkg::*;

    logic              clk1sec;
    logic              btn_mode;
    logic              btn_up;
    logic              btn_down;
    logic              btn_cancel;
    logic [TIME_W-1:0] cur_time;
    logic              set_time;
    logic [TIME_W-1:0] bin_time;
    logic              editing;
    logic [IDX_W-1:0]  edit_field;

    modport master (
        output clk1sec, btn_mode, btn_up, btn_down, btn_cancel, cur_time,
        input  set_time, bin_time, editing, edit_field
    );

    modport slave (
        input  clk1sec, btn_mode, btn_up, btn_down, btn_cancel, cur_time,
        output set_time, bin_time, editing, edit_field
    );

endinterface

// File: rtl/watch_field_step.sv
// Combinational up/down step of one field with wrap-around at both ends of [min_val, max_val].
module watch_field_step
    import watch_pkg::*;
(
    input  logic [FIELD_W-1:0] value,
    input  logic [FIELD_W-1:0] min_val,
    input  logic [FIELD_W-1:0] max_val,
    input  logic               up,
    input  logic               down,
    output logic [FIELD_W-1:0] next_c
);

    // Up and down together cancel out.
    always_comb begin
        next_c = value;
        if (up && !down) begin
            next_c = (value >= max_val) ? min_val : value + FIELD_W'(1);
        end else if (down && !up) begin
            next_c = (value <= min_val) ? max_val : value - FIELD_W'(1);
        end
    end

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven date/time editor producing a one-cycle set_time load for the watch counter.
// Optional idle abort enabled by defining WATCH_EDIT_TIMEOUT_EN.
module watch_time_setter
    import watch_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input logic                clk,
    input logic                rst,
    watch_time_setter_if.slave io
);

    state_e             state_q, state_d;
    watch_time_t        tm_q, tm_d;
    logic               set_time_q, set_time_d;
    logic               editing_q, editing_d;
    logic [IDX_W-1:0]   edit_field_q, edit_field_d;

    logic [FIELD_W-1:0] step_val_c, step_min_c, step_max_c, step_next_c;
    logic               abort_c;
    logic               timeout_c;

    // Select the field under edit for the shared stepper.
    always_comb begin
        step_val_c = tm_q.year;
        step_min_c = YEAR_MIN;
        step_max_c = YEAR_MAX;
        case (state_q)
            E_MONTH: begin step_val_c = tm_q.month;  step_min_c = MONTH_MIN;  step_max_c = MONTH_MAX; end
            E_DAY:   begin step_val_c = tm_q.day;    step_min_c = DAY_MIN;    step_max_c = max_days(tm_q.month); end
            E_HOUR:  begin step_val_c = tm_q.hour;   step_min_c = HOUR_MIN;   step_max_c = HOUR_MAX; end
            E_MIN:   begin step_val_c = tm_q.minute; step_min_c = MINUTE_MIN; step_max_c = MINUTE_MAX; end
            E_SEC:   begin step_val_c = tm_q.second; step_min_c = SECOND_MIN; step_max_c = SECOND_MAX; end
            default: ;
        endcase
    end

    watch_field_step u_step (
        .value   (step_val_c),
        .min_val (step_min_c),
        .max_val (step_max_c),
        .up      (io.btn_up),
        .down    (io.btn_down),
        .next_c  (step_next_c)
    );

`ifdef WATCH_EDIT_TIMEOUT_EN
    localparam int unsigned IDLE_W = 8;

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              any_btn_c;

    // Count seconds without any button while editing; the terminal count acts as cancel.
    always_comb begin
        any_btn_c = io.btn_mode | io.btn_up | io.btn_down | io.btn_cancel;
        idle_d    = '0;
        timeout_c = 1'b0;
        if (is_edit(state_q) && !any_btn_c) begin
            idle_d = idle_q;
            if (io.clk1sec) begin
                idle_d    = idle_q + IDLE_W'(1);
                timeout_c = (idle_d == IDLE_W'(TIMEOUT_SEC));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    logic [FIELD_W-1:0] unused_c;

    assign timeout_c = 1'b0;
    assign unused_c  = FIELD_W'(TIMEOUT_SEC) ^ {{(FIELD_W-1){1'b0}}, io.clk1sec};
`endif

    // Next state, edit registers and registered outputs derived from the next state.
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        abort_c = io.btn_cancel | timeout_c;
        case (state_q)
            IDLE: begin
                if (io.btn_mode) begin
                    state_d = E_YEAR;
                    tm_d    = sanitize(io.cur_time);
                end
            end
            COMMIT: state_d = IDLE;
            default: begin
                if (abort_c) begin
                    state_d = IDLE;
                end else if (io.btn_mode) begin
                    state_d = next_field_state(state_q);
                end else begin
                    case (state_q)
                        E_YEAR: tm_d.year = step_next_c;
                        E_MONTH: begin
                            tm_d.month = step_next_c;
                            if (tm_q.day > max_days(step_next_c)) tm_d.day = max_days(step_next_c);
                        end
                        E_DAY:  tm_d.day    = step_next_c;
                        E_HOUR: tm_d.hour   = step_next_c;
                        E_MIN:  tm_d.minute = step_next_c;
                        E_SEC:  tm_d.second = step_next_c;
                        default: ;
                    endcase
                end
            end
        endcase
        set_time_d   = (state_d == COMMIT);
        editing_d    = is_edit(state_d);
        edit_field_d = state_field(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tm_q         <= '0;
            set_time_q   <= 1'b0;
            editing_q    <= 1'b0;
            edit_field_q <= FIELD_NONE;
        end else begin
            state_q      <= state_d;
            tm_q         <= tm_d;
            set_time_q   <= set_time_d;
            editing_q    <= editing_d;
            edit_field_q <= edit_field_d;
        end
    end

    assign io.set_time   = set_time_q;
    assign io.bin_time   = tm_q;
    assign io.editing    = editing_q;
    assign io.edit_field = edit_field_q;

endmodule

// File: tb/tb_watch_time_setter.sv
// Randomized bench for watch_time_setter against a field-list model, plus literal directed checks.
module tb_watch_time_setter;

    localparam int unsigned TO = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    watch_time_setter_if wif ();

    watch_time_setter #(.TIMEOUT_SEC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .io  (wif)
    );

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    // Model: m_st = -1 idle, 0..5 field being edited, 6 commit.
    int m_st;
    int m_f[6];
    int m_idle;

    function automatic int mdays(input int m);
        if (m == 2) return 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic int fmin(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function int fmax(input int i);
        case (i)
            0:       return 255;
            1:       return 12;
            2:       return mdays(m_f[1]);
            3:       return 23;
            default: return 59;
        endcase
    endfunction

    function logic [47:0] m_bin();
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[47-8*i -: 8] = m_f[i][7:0];
        return r;
    endfunction

    function void model_reset();
        m_st   = -1;
        m_idle = 0;
        for (int i = 0; i < 6; i++) m_f[i] = 0;
    endfunction

    function void model_step(input bit md, input bit u, input bit dn, input bit c,
                             input bit s1, input logic [47:0] cur);
        bit to;
        int v;
        int mo;
        int dy;
        to = 1'b0;
        if (m_st >= 0 && m_st <= 5) begin
`ifdef WATCH_EDIT_TIMEOUT_EN
            if (md || u || dn || c) m_idle = 0;
            else if (s1) begin
                m_idle++;
                if (m_idle == TO) to = 1'b1;
            end
`endif
        end else begin
            m_idle = 0;
        end
        if (m_st == -1) begin
            if (md) begin
                mo = int'(cur[39:32]);
                dy = int'(cur[31:24]);
                if (mo < 1 || mo > 12) mo = 1;
                if (dy < 1 || dy > mdays(mo)) dy = 1;
                m_f[0] = int'(cur[47:40]);
                m_f[1] = mo;
                m_f[2] = dy;
                m_f[3] = int'(cur[23:16]);
                m_f[4] = int'(cur[15:8]);
                m_f[5] = int'(cur[7:0]);
                m_st   = 0;
            end
        end else if (m_st == 6) begin
            m_st = -1;
        end else if (c || to) begin
            m_st = -1;
        end else if (md) begin
            m_st = m_st + 1;
        end else if (u != dn) begin
            v = m_f[m_st];
            if (u) v = (v >= fmax(m_st)) ? fmin(m_st) : v + 1;
            else   v = (v <= fmin(m_st)) ? fmax(m_st) : v - 1;
            m_f[m_st] = v;
            if (m_st == 1 && m_f[2] > mdays(m_f[1])) m_f[2] = mdays(m_f[1]);
        end
    endfunction

    function void check(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare DUT outputs with the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("set_time",   48'(wif.set_time),   48'(m_st == 6));
            check("editing",    48'(wif.editing),    48'(m_st >= 0 && m_st <= 5));
            check("edit_field", 48'(wif.edit_field), (m_st >= 0 && m_st <= 5) ? 48'(m_st) : 48'd7);
            check("bin_time",   wif.bin_time,        m_bin());
        end
    end

    task automatic cyc(input bit md, input bit u, input bit dn, input bit c,
                       input bit s1, input logic [47:0] cur);
        wif.btn_mode   = md;
        wif.btn_up     = u;
        wif.btn_down   = dn;
        wif.btn_cancel = c;
        wif.clk1sec    = s1;
        wif.cur_time   = cur;
        @(posedge clk);
        model_step(md, u, dn, c, s1, cur);
        #1;
        wif.btn_mode   = 1'b0;
        wif.btn_up     = 1'b0;
        wif.btn_down   = 1'b0;
        wif.btn_cancel = 1'b0;
        wif.clk1sec    = 1'b0;
    endtask

    task automatic press(input bit md, input bit u, input bit dn, input bit c, input int n);
        for (int i = 0; i < n; i++) cyc(md, u, dn, c, 1'b0, wif.cur_time);
    endtask

    logic [47:0] cur;

    initial begin
        rst            = 1'b1;
        wif.btn_mode   = 1'b0;
        wif.btn_up     = 1'b0;
        wif.btn_down   = 1'b0;
        wif.btn_cancel = 1'b0;
        wif.clk1sec    = 1'b0;
        wif.cur_time   = '0;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_set_time",   48'(wif.set_time),   48'd0);
        check("rst_bin_time",   wif.bin_time,        48'h0);
        check("rst_editing",    48'(wif.editing),    48'd0);
        check("rst_edit_field", 48'(wif.edit_field), 48'd7);

        // Full pass with no edits loads the snapshot back.
        cyc(1, 0, 0, 0, 0, 48'h2A031F173B3B);
        press(1, 0, 0, 0, 6);
        check("t1_set_time", 48'(wif.set_time), 48'd1);
        check("t1_bin_time", wif.bin_time, 48'h2A031F173B3B);
        check("t1_model",    m_bin(),      48'h2A031F173B3B);
        check("t1_editing",  48'(wif.editing), 48'd0);
        press(0, 0, 0, 0, 1);
        check("t1_strobe_one_cycle", 48'(wif.set_time), 48'd0);

        // Wrap at the top of year and month, bottom of hour.
        cyc(1, 0, 0, 0, 0, 48'hFF0C01000000);
        press(0, 1, 0, 0, 1);
        check("t2_year_wrap", 48'(wif.bin_time[47:40]), 48'h00);
        press(1, 0, 0, 0, 1);
        press(0, 1, 0, 0, 1);
        check("t2_month_wrap", 48'(wif.bin_time[39:32]), 48'h01);
        press(1, 0, 0, 0, 2);
        press(0, 0, 1, 0, 1);
        check("t2_hour_wrap", 48'(wif.bin_time[23:16]), 48'h17);
        press(0, 0, 0, 1, 1);
        check("t2_cancel", 48'(wif.editing), 48'd0);

        // Month change clamps the day.
        cyc(1, 0, 0, 0, 0, 48'h00011F000000);
        press(1, 0, 0, 0, 1);
        press(0, 1, 0, 0, 1);
        check("t3_clamp", 48'(wif.bin_time[39:24]), 48'h021C);
        check("t3_model", m_bin(), 48'h00021C000000);
        press(1, 0, 0, 0, 5);
        check("t3_commit", 48'(wif.set_time), 48'd1);
        check("t3_bin",    wif.bin_time,      48'h00021C000000);
        press(0, 0, 0, 0, 1);

        // All-zero snapshot is sanitised.
        cyc(1, 0, 0, 0, 0, 48'h0);
        check("t4_bin",   wif.bin_time, 48'h000101000000);
        check("t4_field", 48'(wif.edit_field), 48'd0);

        // Simultaneous-button priorities.
        press(1, 0, 0, 0, 2);
        press(0, 1, 1, 0, 1);
        check("t5_updown", wif.bin_time, 48'h000101000000);
        press(1, 1, 0, 0, 1);
        check("t5_mode_up_field", 48'(wif.edit_field), 48'd3);
        check("t5_mode_up_bin",   wif.bin_time, 48'h000101000000);
        press(1, 0, 0, 1, 1);
        check("t5_cancel_mode", 48'(wif.editing), 48'd0);
        press(0, 0, 0, 0, 1);
        check("t5_no_set", 48'(wif.set_time), 48'd0);
        check("t5_keep",   wif.bin_time, 48'h000101000000);

        // Reset during E_MIN.
        cyc(1, 0, 0, 0, 0, 48'h05060708090A);
        press(1, 0, 0, 0, 4);
        press(0, 1, 0, 0, 1);
        check("t6_min_edit", 48'(wif.bin_time[15:8]), 48'h0A);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_rst_bin",   wif.bin_time, 48'h0);
        check("t6_rst_field", 48'(wif.edit_field), 48'd7);
        @(posedge clk);
        #1 rst = 1'b0;
        press(0, 0, 0, 0, 2);
        check("t6_no_set", 48'(wif.set_time), 48'd0);

`ifdef WATCH_EDIT_TIMEOUT_EN
        // Idle timeout, restarted by a button after two seconds.
        cyc(1, 0, 0, 0, 0, 48'h010101000000);
        cyc(0, 0, 0, 0, 1, wif.cur_time);
        cyc(0, 0, 0, 0, 0, wif.cur_time);
        cyc(0, 0, 0, 0, 1, wif.cur_time);
        cyc(0, 1, 0, 0, 0, wif.cur_time);
        cyc(0, 0, 0, 0, 1, wif.cur_time);
        cyc(0, 0, 0, 0, 1, wif.cur_time);
        check("to_restart", 48'(wif.editing), 48'd1);
        cyc(0, 0, 0, 0, 1, wif.cur_time);
        check("to_abort",  48'(wif.editing),  48'd0);
        check("to_no_set", 48'(wif.set_time), 48'd0);
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cur[47:40] = 8'($urandom_range(0, 255));
            cur[39:32] = 8'($urandom_range(0, 15));
            cur[31:24] = 8'($urandom_range(0, 40));
            cur[23:16] = 8'($urandom_range(0, 23));
            cur[15:8]  = 8'($urandom_range(0, 59));
            cur[7:0]   = 8'($urandom_range(0, 59));
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, cur);
        end

        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
